// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus launcher that paces bytes into a UART_TX.
// Bytes written on WR_DATA/WR_EN are queued. Each byte is then presented on
// P_DATA with a Data_Valid request, timed against the transmitter's Busy.
// Optional build macro UART_TX_FEEDER_OVF_EN adds a sticky overflow flag OVF
// and its synchronous clear OVF_CLR.
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_WIDTH:0]   FIFO_COUNT,
  input  logic                  Busy,
`ifdef UART_TX_FEEDER_OVF_EN
  output logic                  OVF,
  input  logic                  OVF_CLR,
`endif
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH:0]   count_nxt_s;
  logic                  full_r;
  logic                  empty_r;
  logic                  wr_fire_s;
  logic                  pop_s;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [DATA_WIDTH-1:0] p_data_r;
  logic [DATA_WIDTH-1:0] p_data_nxt_s;
  logic                  dv_r;
  logic                  dv_nxt_s;

  // A write is taken only when the FIFO was not full at the start of the cycle;
  // a pop in the same cycle does not rescue a write into a full FIFO.
  assign wr_fire_s = WR_EN & ~full_r;

  // Occupancy after this cycle's write and pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_fire_s, pop_s})
      2'b10:   count_nxt_s = count_r + (ADDR_WIDTH+1)'(1);
      2'b01:   count_nxt_s = count_r - (ADDR_WIDTH+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; intentionally not reset so that it maps onto plain RAM.
  always_ff @(posedge CLK) begin
    if (wr_fire_s) begin
      mem_r[wr_ptr_r] <= WR_DATA;
    end
  end

  // Pointers, count and the registered FULL/EMPTY flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == '0);
    end
  end

  // Launcher next-state logic: pop and launch from IDLE, hold the request
  // until the transmitter reports busy, then wait for the frame to finish.
  always_comb begin
    state_nxt_s  = state_r;
    p_data_nxt_s = p_data_r;
    dv_nxt_s     = dv_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_r && !Busy) begin
          pop_s        = 1'b1;
          p_data_nxt_s = mem_r[rd_ptr_r];
          dv_nxt_s     = 1'b1;
          state_nxt_s  = WAIT_BUSY;
        end else begin
          dv_nxt_s     = 1'b0;
        end
      end
      WAIT_BUSY: begin
        if (Busy) begin
          dv_nxt_s    = 1'b0;
          state_nxt_s = WAIT_DONE;
        end else begin
          dv_nxt_s    = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!Busy) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        dv_nxt_s    = 1'b0;
      end
    endcase
  end

  // Launcher state and the registered UART-side outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r  <= IDLE;
      p_data_r <= '0;
      dv_r     <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      p_data_r <= p_data_nxt_s;
      dv_r     <= dv_nxt_s;
    end
  end

`ifdef UART_TX_FEEDER_OVF_EN
  logic ovf_r;

  // Sticky overflow flag; a new overflow outranks a clear in the same cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_r <= 1'b0;
    end else if (WR_EN && full_r) begin
      ovf_r <= 1'b1;
    end else if (OVF_CLR) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign OVF = ovf_r;
`endif

  assign FULL       = full_r;
  assign EMPTY      = empty_r;
  assign FIFO_COUNT = count_r;
  assign P_DATA     = p_data_r;
  assign Data_Valid = dv_r;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder paired with a small UART_TX busy model:
// Busy rises one cycle after Data_Valid and stays high for 11 cycles.
module tb_uart_tx_feeder;

  logic       CLK;
  logic       RST;
  logic [7:0] WR_DATA;
  logic       WR_EN;
  logic       FULL;
  logic       EMPTY;
  logic [3:0] FIFO_COUNT;
  logic       Busy;
  logic [7:0] P_DATA;
  logic       Data_Valid;
`ifdef UART_TX_FEEDER_OVF_EN
  logic       OVF;
  logic       OVF_CLR;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // UART_TX model state and launch capture log
  int         busy_cnt;
  logic       busy_force;
  logic [7:0] cap [64];
  int         cap_n = 0;

  assign Busy = (busy_cnt != 0) | busy_force;

  uart_tx_feeder #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .ADDR_WIDTH(3)) dut (
    .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_EN(WR_EN),
    .FULL(FULL), .EMPTY(EMPTY), .FIFO_COUNT(FIFO_COUNT), .Busy(Busy),
`ifdef UART_TX_FEEDER_OVF_EN
    .OVF(OVF), .OVF_CLR(OVF_CLR),
`endif
    .P_DATA(P_DATA), .Data_Valid(Data_Valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // UART_TX stand-in: accepts a launch when idle, then stays busy 11 cycles
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_cnt <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end else if (Data_Valid && !busy_force) begin
      busy_cnt <= 11;
      if (cap_n < 64) cap[cap_n] <= P_DATA;
      cap_n <= cap_n + 1;
    end
  end

  typedef struct {
    logic       wr_en;
    logic [7:0] data;
    logic [3:0] exp_count;
    logic       exp_full;
    logic       exp_empty;
  } vec_t;

  vec_t tbl [9];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    WR_EN = 1'b1;
    WR_DATA = d;
    tick();
    WR_EN = 1'b0;
  endtask

  initial begin
    int base;
    int seen;
    RST = 1'b0;
    WR_EN = 1'b0;
    WR_DATA = 8'h00;
    busy_force = 1'b0;
`ifdef UART_TX_FEEDER_OVF_EN
    OVF_CLR = 1'b0;
`endif
    for (int i = 0; i < 9; i++) begin
      tbl[i].wr_en     = 1'b1;
      tbl[i].data      = (i < 8) ? 8'(i + 1) : 8'hFF;
      tbl[i].exp_count = (i < 8) ? 4'(i + 1) : 4'd8;
      tbl[i].exp_full  = (i >= 7);
      tbl[i].exp_empty = 1'b0;
    end

    // reset state
    ticks(3);
    check("rst_count", 32'(FIFO_COUNT), 32'd0);
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_pdata", 32'(P_DATA), 32'd0);
    check("rst_dv", 32'(Data_Valid), 32'd0);
    RST = 1'b1;
    ticks(2);

    // 1: single write, launch one edge after EMPTY falls
    base = cap_n;
    write_byte(8'hA5);
    check("t1_empty_E", 32'(EMPTY), 32'd0);
    check("t1_count_E", 32'(FIFO_COUNT), 32'd1);
    check("t1_dv_E", 32'(Data_Valid), 32'd0);
    tick();
    check("t1_dv_E1", 32'(Data_Valid), 32'd1);
    check("t1_pdata", 32'(P_DATA), 32'hA5);
    check("t1_count_E1", 32'(FIFO_COUNT), 32'd0);
    check("t1_empty_E1", 32'(EMPTY), 32'd1);
    tick();
    check("t1_dv_width2", 32'(Data_Valid), 32'd1);
    tick();
    check("t1_dv_drop", 32'(Data_Valid), 32'd0);
    ticks(14);
    check("t1_launches", 32'(cap_n - base), 32'd1);
    check("t1_cap", 32'(cap[base]), 32'hA5);
    check("t1_pdata_hold", 32'(P_DATA), 32'hA5);
    check("t1_dv_idle", 32'(Data_Valid), 32'd0);

    // 2: burst of 8 plus a dropped 9th, table driven with the launcher held off
    busy_force = 1'b1;
    base = cap_n;
    for (int i = 0; i < 9; i++) begin
      WR_EN = tbl[i].wr_en;
      WR_DATA = tbl[i].data;
      tick();
      check($sformatf("t2_count_%0d", i), 32'(FIFO_COUNT), 32'(tbl[i].exp_count));
      check($sformatf("t2_full_%0d", i), 32'(FULL), 32'(tbl[i].exp_full));
      check($sformatf("t2_empty_%0d", i), 32'(EMPTY), 32'(tbl[i].exp_empty));
    end
    WR_EN = 1'b0;
    busy_force = 1'b0;
    tick();
    check("t2_first_dv", 32'(Data_Valid), 32'd1);
    check("t2_full_after_pop", 32'(FULL), 32'd0);
    check("t2_count_after_pop", 32'(FIFO_COUNT), 32'd7);
    ticks(120);
    check("t2_launches", 32'(cap_n - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_order_%0d", i), 32'(cap[base + i]), 32'(i + 1));
    end
    check("t2_empty_end", 32'(EMPTY), 32'd1);

    // 3: write and pop in the same edge at count 3
    busy_force = 1'b1;
    base = cap_n;
    write_byte(8'h10);
    write_byte(8'h11);
    write_byte(8'h12);
    check("t3_count_pre", 32'(FIFO_COUNT), 32'd3);
    WR_EN = 1'b1;
    WR_DATA = 8'h13;
    busy_force = 1'b0;
    tick();
    WR_EN = 1'b0;
    check("t3_count_same", 32'(FIFO_COUNT), 32'd3);
    check("t3_dv", 32'(Data_Valid), 32'd1);
    check("t3_pdata", 32'(P_DATA), 32'h10);
    ticks(60);
    check("t3_launches", 32'(cap_n - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_order_%0d", i), 32'(cap[base + i]), 32'(8'h10 + i));
    end

    // 4: Busy held high in IDLE blocks launches until released
    busy_force = 1'b1;
    base = cap_n;
    write_byte(8'h20);
    write_byte(8'h21);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (Data_Valid) seen++;
    end
    check("t4_no_dv_held", 32'(seen), 32'd0);
    busy_force = 1'b0;
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (Data_Valid && seen == 0) seen = i + 1;
    end
    check("t4_launch_within_2", 32'(seen != 0), 32'd1);
    check("t4_pdata", 32'(P_DATA), 32'h20);
    ticks(30);
    check("t4_launches", 32'(cap_n - base), 32'd2);
    check("t4_cap1", 32'(cap[base + 1]), 32'h21);

    // 5: async reset in WAIT_DONE with 4 bytes still queued
    busy_force = 1'b1;
    for (int i = 0; i < 5; i++) write_byte(8'(8'h30 + i));
    busy_force = 1'b0;
    ticks(3);
    check("t5_count_pre", 32'(FIFO_COUNT), 32'd4);
    check("t5_dv_pre", 32'(Data_Valid), 32'd0);
    check("t5_busy_pre", 32'(Busy), 32'd1);
    base = cap_n;
    RST = 1'b0;
    #1;
    check("t5_count_rst", 32'(FIFO_COUNT), 32'd0);
    check("t5_empty_rst", 32'(EMPTY), 32'd1);
    check("t5_dv_rst", 32'(Data_Valid), 32'd0);
    check("t5_pdata_rst", 32'(P_DATA), 32'd0);
    ticks(2);
    RST = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (Data_Valid) seen++;
    end
    check("t5_no_dv_after", 32'(seen), 32'd0);
    check("t5_no_launch", 32'(cap_n - base), 32'd0);

`ifdef UART_TX_FEEDER_OVF_EN
    // 6: sticky overflow flag, clear, and clear losing to a new overflow
    busy_force = 1'b1;
    check("t6_ovf_init", 32'(OVF), 32'd0);
    for (int i = 0; i < 8; i++) write_byte(8'(8'h40 + i));
    check("t6_full", 32'(FULL), 32'd1);
    check("t6_ovf_none", 32'(OVF), 32'd0);
    write_byte(8'hEE);
    check("t6_ovf_set", 32'(OVF), 32'd1);
    check("t6_count", 32'(FIFO_COUNT), 32'd8);
    OVF_CLR = 1'b1;
    tick();
    OVF_CLR = 1'b0;
    check("t6_ovf_clr", 32'(OVF), 32'd0);
    OVF_CLR = 1'b1;
    write_byte(8'hEF);
    OVF_CLR = 1'b0;
    check("t6_ovf_wins", 32'(OVF), 32'd1);
    RST = 1'b0;
    #1;
    check("t6_ovf_rst", 32'(OVF), 32'd0);
    busy_force = 1'b0;
    tick();
    RST = 1'b1;
`endif

    ticks(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
